dsp_result_checker: RTL and testbench

Synthesizable self-checking monitor that sits directly downstream of a DSP adder DUT in the regression harness. It consumes the operands driven into the DUT and the DUT's sum output, forms a latency-aligned golden sum, and compares them. It waits out the global-set/reset settle window, then checks a fixed number of qualified samples and reports pass/fail, error count and the first mismatch.

---
 rtl/dsp_regress_pkg.sv | 16 +
 rtl/dsp_result_checker_if.sv | 27 ++
 rtl/delay_line.sv | 29 ++
 rtl/dsp_result_checker.sv | 101 ++++++++++
 tb/tb_dsp_result_checker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dsp_regress_pkg.sv
// Shared types and helpers for the DSP regression checker slice.
package dsp_regress_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DONE   = 2'd2
    } chk_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/dsp_result_checker_if.sv
// Operand/result bus seen by the checker plus its status outputs.
interface dsp_result_checker_if
    import dsp_regress_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] check_count;
    logic [WIDTH-1:0] first_got;
    logic [WIDTH-1:0] first_exp;

    modport master (
        output in_valid, a, b, y,
        input  done, pass, err_count, check_count, first_got, first_exp
    );

    modport slave (
        input  in_valid, a, b, y,
        output done, pass, err_count, check_count, first_got, first_exp
    );
endinterface

// File: rtl/delay_line.sv
// Fixed-depth register pipe, cleared on reset; wires straight through at depth 0.
module delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_pipe
            logic [W-1:0] pipe_q [DEPTH];

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
                end else begin
                    pipe_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end

            assign q_o = pipe_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/dsp_result_checker.sv
// Compares a DSP adder's output against a latency-aligned golden sum after the
// post-reset settle window, then reports pass/fail, error count and first mismatch.
module dsp_result_checker
    import dsp_regress_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LATENCY    = 0,
    parameter int SETTLE     = 5000,
    parameter int NUM_CHECKS = 16
) (
    input  logic clock,
    input  logic reset,
    dsp_result_checker_if.slave chk
);
    localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CHECKS_TGT  = CNT_W'(NUM_CHECKS);

    chk_state_t       state_q, state_d;
    logic [SW-1:0]    settle_q, settle_d;
    logic [CNT_W-1:0] check_q, check_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [WIDTH-1:0] first_got_q, first_got_d;
    logic [WIDTH-1:0] first_exp_q, first_exp_d;

    logic [WIDTH-1:0] exp_now, exp_dly;
    logic             vld_dly;
    logic             cmp_en;
    logic             mismatch;

    assign exp_now = chk.a + chk.b;

    // The pipe keeps filling during settle so the first CHECK cycle is already aligned.
    delay_line #(.W(WIDTH + 1), .DEPTH(LATENCY)) u_align (
        .clock (clock),
        .reset (reset),
        .d_i   ({chk.in_valid, exp_now}),
        .q_o   ({vld_dly, exp_dly})
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_SETTLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SETTLE: if (settle_q == SETTLE_LAST) state_d = ST_CHECK;
            ST_CHECK:  if (cmp_en && sat_inc(check_q) == CHECKS_TGT) state_d = ST_DONE;
            default:   state_d = ST_DONE;
        endcase
    end

    always_comb begin
        cmp_en          = (state_q == ST_CHECK) && vld_dly;
        mismatch        = (chk.y != exp_dly);
        chk.done        = (state_q == ST_DONE);
        chk.pass        = (state_q == ST_DONE) && (err_q == '0);
        chk.err_count   = err_q;
        chk.check_count = check_q;
        chk.first_got   = first_got_q;
        chk.first_exp   = first_exp_q;
    end

    always_comb begin
        settle_d    = settle_q;
        check_d     = check_q;
        err_d       = err_q;
        first_got_d = first_got_q;
        first_exp_d = first_exp_q;
        if (state_q == ST_SETTLE && settle_q != SETTLE_LAST) settle_d = settle_q + SW'(1);
        if (cmp_en) begin
            check_d = sat_inc(check_q);
            if (mismatch) begin
                err_d = sat_inc(err_q);
                // err_q saturates and never returns to zero, so zero marks "no mismatch yet".
                if (err_q == '0) begin
                    first_got_d = chk.y;
                    first_exp_d = exp_dly;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle_q    <= '0;
            check_q     <= '0;
            err_q       <= '0;
            first_got_q <= '0;
            first_exp_q <= '0;
        end else begin
            settle_q    <= settle_d;
            check_q     <= check_d;
            err_q       <= err_d;
            first_got_q <= first_got_d;
            first_exp_q <= first_exp_d;
        end
    end
endmodule

// File: tb/tb_dsp_result_checker.sv
// Bench for dsp_result_checker: two instances (latency 0 and 2) against an edge-indexed history model.
module tb_dsp_result_checker;
    localparam int SETTLE_P = 8;
    localparam int NCHK     = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dsp_result_checker_if #(.WIDTH(8)) if0 ();
    dsp_result_checker_if #(.WIDTH(8)) if2 ();

    dsp_result_checker #(.WIDTH(8), .LATENCY(0), .SETTLE(SETTLE_P), .NUM_CHECKS(NCHK)) dut0 (
        .clock (clk),
        .reset (rst_n),
        .chk   (if0)
    );

    dsp_result_checker #(.WIDTH(8), .LATENCY(2), .SETTLE(SETTLE_P), .NUM_CHECKS(NCHK)) dut2 (
        .clock (clk),
        .reset (rst_n),
        .chk   (if2)
    );

    int checks = 0;
    int errors = 0;

    // Model: every edge since reset release is numbered; edge n judges the inputs
    // recorded at edge n-latency, but only once n is past the settle window.
    int         n_edge;
    logic       hv [0:255];
    logic [7:0] he [0:255];
    int         m_chk  [2];
    int         m_err  [2];
    logic [7:0] m_fg   [2];
    logic [7:0] m_fe   [2];
    logic       m_done [2];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] s_of(input int k);
        return 8'((3 * k + 1) + (5 * k + 2));
    endfunction

    task automatic drive(input int kind, input int k);
        logic       v;
        logic [7:0] a, b, y0, y2;
        v = 1'b1; a = '0; b = '0; y0 = '0; y2 = '0;
        case (kind)
            0: begin a = 8'h00; b = 8'hFE; y0 = 8'hFE; y2 = 8'hFE; end
            1: begin a = 8'h7F; b = 8'h01; y0 = 8'h80; y2 = 8'h80; end
            2: begin a = 8'h7F; b = 8'h01; y0 = 8'h7F; y2 = 8'h7F; end
            3: begin a = 8'(3 * k + 1); b = 8'(5 * k + 2); y0 = s_of(k); y2 = s_of(k - 2); end
            4: begin a = 8'(3 * k + 1); b = 8'(5 * k + 2); y0 = s_of(k); y2 = s_of(k - 1); end
            5: begin a = 8'd10; b = 8'd20; y0 = (k <= SETTLE_P) ? 8'd0 : 8'd30; y2 = y0; end
            6: begin v = (k % 3 == 0); a = 8'(k); b = 8'd1; y0 = 8'(k + 1); y2 = 8'(k - 1); end
            7: begin a = 8'(k); b = 8'd2; y0 = 8'(k + 3); y2 = y0; end
            default: v = 1'b0;
        endcase
        if0.in_valid = v; if0.a = a; if0.b = b; if0.y = y0;
        if2.in_valid = v; if2.a = a; if2.b = b; if2.y = y2;
    endtask

    task automatic model_reset();
        n_edge = 0;
        for (int i = 0; i < 2; i++) begin
            m_chk[i] = 0; m_err[i] = 0; m_fg[i] = '0; m_fe[i] = '0; m_done[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int         src;
        logic [7:0] yy;
        n_edge++;
        if (n_edge < 256) begin
            hv[n_edge] = if0.in_valid;
            he[n_edge] = 8'(if0.a + if0.b);
        end
        for (int i = 0; i < 2; i++) begin
            src = n_edge - ((i == 0) ? 0 : 2);
            yy  = (i == 0) ? if0.y : if2.y;
            if (!m_done[i] && n_edge > SETTLE_P && src >= 1 && src < 256 && hv[src]) begin
                m_chk[i]++;
                if (yy != he[src]) begin
                    if (m_err[i] == 0) begin
                        m_fg[i] = yy;
                        m_fe[i] = he[src];
                    end
                    if (m_err[i] < 65535) m_err[i]++;
                end
                if (m_chk[i] == NCHK) m_done[i] = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("L0 done",  32'(if0.done),        32'(m_done[0]));
        chk("L0 pass",  32'(if0.pass),        32'(m_done[0] && m_err[0] == 0));
        chk("L0 errs",  32'(if0.err_count),   32'(m_err[0]));
        chk("L0 cnt",   32'(if0.check_count), 32'(m_chk[0]));
        chk("L0 fgot",  32'(if0.first_got),   32'(m_fg[0]));
        chk("L0 fexp",  32'(if0.first_exp),   32'(m_fe[0]));
        chk("L2 done",  32'(if2.done),        32'(m_done[1]));
        chk("L2 pass",  32'(if2.pass),        32'(m_done[1] && m_err[1] == 0));
        chk("L2 errs",  32'(if2.err_count),   32'(m_err[1]));
        chk("L2 cnt",   32'(if2.check_count), 32'(m_chk[1]));
        chk("L2 fgot",  32'(if2.first_got),   32'(m_fg[1]));
        chk("L2 fexp",  32'(if2.first_exp),   32'(m_fe[1]));
    endtask

    // Entered and left on a falling edge; each iteration covers one rising edge k.
    task automatic step(input int kind, input int kfrom, input int kto);
        for (int k = kfrom; k <= kto; k++) begin
            drive(kind, k);
            model_edge();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(-1, 0);
        model_reset();
        #1;
        compare_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Match: first check at edge 9, done visible in cycle 13.
        do_reset();
        step(0, 1, 11);
        chk("match done@11", 32'(if0.done), 32'd0);
        chk("match cnt@11",  32'(if0.check_count), 32'd3);
        step(0, 12, 12);
        chk("match done@12", 32'(if0.done), 32'd1);
        chk("match pass",    32'(if0.pass), 32'd1);
        chk("match errs",    32'(if0.err_count), 32'd0);
        chk("match cnt",     32'(if0.check_count), 32'd4);

        // Wrap: 7F + 01 = 80.
        do_reset();
        step(1, 1, 13);
        chk("wrap pass", 32'(if0.pass), 32'd1);
        chk("wrap done", 32'(if0.done), 32'd1);

        do_reset();
        step(2, 1, 13);
        chk("wrapbad errs", 32'(if0.err_count), 32'd4);
        chk("wrapbad fgot", 32'(if0.first_got), 32'h7F);
        chk("wrapbad fexp", 32'(if0.first_exp), 32'h80);
        chk("wrapbad pass", 32'(if0.pass), 32'd0);
        chk("wrapbad done", 32'(if0.done), 32'd1);

        // Latency 2, correctly delayed result.
        do_reset();
        step(3, 1, 14);
        chk("lat2 pass",  32'(if2.pass), 32'd1);
        chk("lat2 done",  32'(if2.done), 32'd1);
        chk("lat0 pass",  32'(if0.pass), 32'd1);

        // Latency 2 fed a 1-cycle-delayed result: successive sums differ by 8.
        do_reset();
        step(4, 1, 14);
        chk("lat1on2 errs", 32'(if2.err_count), 32'd4);
        chk("lat1on2 pass", 32'(if2.pass), 32'd0);

        // Wrong result only inside the settle window.
        do_reset();
        step(5, 1, 14);
        chk("settle errs L0", 32'(if0.err_count), 32'd0);
        chk("settle pass L0", 32'(if0.pass), 32'd1);
        chk("settle pass L2", 32'(if2.pass), 32'd1);

        // Sparse valid: every 3rd edge; L0 checks at edges 9, 12, 15, 18.
        do_reset();
        step(6, 1, 9);
        chk("sparse cnt@9",   32'(if0.check_count), 32'd1);
        step(6, 10, 11);
        chk("sparse cnt@11",  32'(if0.check_count), 32'd1);
        step(6, 12, 17);
        chk("sparse cnt@17",  32'(if0.check_count), 32'd3);
        chk("sparse done@17", 32'(if0.done), 32'd0);
        step(6, 18, 18);
        chk("sparse done@18", 32'(if0.done), 32'd1);
        chk("sparse cnt@18",  32'(if0.check_count), 32'd4);
        chk("sparse pass",    32'(if0.pass), 32'd1);
        step(6, 19, 20);
        chk("sparse L2 done", 32'(if2.done), 32'd1);
        chk("sparse L2 pass", 32'(if2.pass), 32'd1);

        // Mid-run reset with two errors recorded.
        do_reset();
        step(7, 1, 10);
        chk("mid errs",  32'(if0.err_count), 32'd2);
        chk("mid fgot",  32'(if0.first_got), 32'h0C);
        chk("mid fexp",  32'(if0.first_exp), 32'h0B);
        #2;
        rst_n = 1'b0;
        drive(-1, 0);
        model_reset();
        #1;
        chk("rst errs",  32'(if0.err_count), 32'd0);
        chk("rst cnt",   32'(if0.check_count), 32'd0);
        chk("rst fgot",  32'(if0.first_got), 32'd0);
        chk("rst fexp",  32'(if0.first_exp), 32'd0);
        chk("rst done",  32'(if0.done), 32'd0);
        chk("rst pass",  32'(if0.pass), 32'd0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 8);
        chk("restart cnt@8", 32'(if0.check_count), 32'd0);
        step(1, 9, 9);
        chk("restart cnt@9", 32'(if0.check_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
